// File: rtl/mem_io_bridge.sv
// rtl/mem_io_bridge.sv - bus bridge from the single-cycle core to the data RAM and board peripherals
// Loads are combinational; stores and peripheral state commit on the rising clk edge.
module mem_io_bridge #(
  parameter int DRAM_AW           = 14,
  parameter int SCAN_DIV          = 20000,
  parameter int IO_BUS_WIDTH_ADDR = 32,
  parameter int IO_BUS_WIDTH_CTRL = 4,
  parameter int IO_BUS_WIDTH_DATA = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [IO_BUS_WIDTH_ADDR-1:0] mem_addr,
  input  logic [IO_BUS_WIDTH_CTRL-1:0] mem_ctrl,
  input  logic [IO_BUS_WIDTH_DATA-1:0] mem_wd,
  input  logic                         mem_we,
  output logic [IO_BUS_WIDTH_DATA-1:0] mem_rd,
  output logic [DRAM_AW-1:0]           dram_addr,
  output logic [31:0]                  dram_wd,
  output logic                         dram_we,
  input  logic [31:0]                  dram_rd,
  input  logic [23:0]                  sw,
  input  logic [4:0]                   btn,
  output logic [23:0]                  led,
  output logic [7:0]                   seg_en,
  output logic [7:0]                   seg_code
);

  localparam logic [11:0] OFF_SEG  = 12'h000;
  localparam logic [11:0] OFF_TCNT = 12'h020;
  localparam logic [11:0] OFF_TDIV = 12'h024;
  localparam logic [11:0] OFF_LED  = 12'h060;
  localparam logic [11:0] OFF_SW   = 12'h070;
  localparam logic [11:0] OFF_BTN  = 12'h078;

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic [23:0]       led_q, led_d;
  logic [31:0]       seg_q, seg_d;
  logic [31:0]       tcnt_q, tcnt_d;
  logic [31:0]       tdiv_q, tdiv_d;
  logic [31:0]       p_q, p_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]        digit_q, digit_d;
  logic [23:0]       sw_s1_q, sw_s2_q;
  logic [4:0]        btn_s1_q, btn_s2_q;

  logic        periph_sel;
  logic        wr_en;
  logic [11:0] off;
  logic        is_byte, is_half, is_unsigned;
  logic        wr_seg, wr_tcnt, wr_tdiv, wr_led;
  logic        timer_tick;
  logic        scan_wrap;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_data;
  logic [31:0] merged;
  logic [31:0] periph_rd;
  logic [3:0]  cur_nibble;

  // mem_we is the store strobe; the copy in mem_ctrl[0] is deliberately ignored.
  logic ctrl_we_unused;
  assign ctrl_we_unused = mem_ctrl[0];

  assign periph_sel  = (mem_addr[31:12] == 20'hFFFFF);
  assign wr_en       = mem_we & ~rst;
  assign off         = mem_addr[11:0];
  assign is_byte     = (mem_ctrl[2:1] == 2'b10);
  assign is_half     = (mem_ctrl[2:1] == 2'b01);
  assign is_unsigned = mem_ctrl[3];

  assign wr_seg  = wr_en & periph_sel & (off == OFF_SEG);
  assign wr_tcnt = wr_en & periph_sel & (off == OFF_TCNT);
  assign wr_tdiv = wr_en & periph_sel & (off == OFF_TDIV);
  assign wr_led  = wr_en & periph_sel & (off == OFF_LED);

  assign dram_addr = mem_addr[DRAM_AW+1:2];
  assign dram_wd   = merged;
  assign dram_we   = wr_en & ~periph_sel;

  always_comb begin
    lane_b = 8'h00;
    case (mem_addr[1:0])
      2'd0:    lane_b = dram_rd[7:0];
      2'd1:    lane_b = dram_rd[15:8];
      2'd2:    lane_b = dram_rd[23:16];
      default: lane_b = dram_rd[31:24];
    endcase
    lane_h = mem_addr[1] ? dram_rd[31:16] : dram_rd[15:0];
    if (is_byte) begin
      load_data = {{24{~is_unsigned & lane_b[7]}}, lane_b};
    end else if (is_half) begin
      load_data = {{16{~is_unsigned & lane_h[15]}}, lane_h};
    end else begin
      load_data = dram_rd;
    end
  end

  // Sub-word stores are read-modify-write on the asynchronous RAM word.
  always_comb begin
    merged = dram_rd;
    if (is_byte) begin
      case (mem_addr[1:0])
        2'd0:    merged[7:0]   = mem_wd[7:0];
        2'd1:    merged[15:8]  = mem_wd[7:0];
        2'd2:    merged[23:16] = mem_wd[7:0];
        default: merged[31:24] = mem_wd[7:0];
      endcase
    end else if (is_half) begin
      if (mem_addr[1]) begin
        merged[31:16] = mem_wd[15:0];
      end else begin
        merged[15:0] = mem_wd[15:0];
      end
    end else begin
      merged = mem_wd;
    end
  end

  always_comb begin
    periph_rd = 32'h0;
    case (off)
      OFF_SEG:  periph_rd = seg_q;
      OFF_TCNT: periph_rd = tcnt_q;
      OFF_TDIV: periph_rd = tdiv_q;
      OFF_LED:  periph_rd = {8'h00, led_q};
      OFF_SW:   periph_rd = {8'h00, sw_s2_q};
      OFF_BTN:  periph_rd = {27'h0, btn_s2_q};
      default:  periph_rd = 32'h0;
    endcase
  end

  assign mem_rd = periph_sel ? periph_rd : load_data;

  // A >= compare lets the prescaler recover if it is ever beyond a shrunken divisor.
  assign timer_tick = (tdiv_q != 32'h0) && (p_q >= tdiv_q - 32'd1);
  assign scan_wrap  = (scan_cnt_q == SCAN_LAST);

  always_comb begin
    led_d  = led_q;
    seg_d  = seg_q;
    tdiv_d = tdiv_q;
    tcnt_d = tcnt_q;
    p_d    = p_q;
    if (wr_led) led_d = mem_wd[23:0];
    if (wr_seg) seg_d = mem_wd;
    if (wr_tdiv) tdiv_d = mem_wd;
    if (timer_tick) begin
      tcnt_d = tcnt_q + 32'd1;
      p_d    = 32'h0;
    end else if (tdiv_q != 32'h0) begin
      p_d = p_q + 32'd1;
    end
    if (wr_tdiv) p_d = 32'h0;
    if (wr_tcnt) begin
      tcnt_d = mem_wd;
      p_d    = 32'h0;
    end
    scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
    digit_d    = scan_wrap ? digit_q + 3'd1 : digit_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q      <= '0;
      seg_q      <= '0;
      tcnt_q     <= '0;
      tdiv_q     <= '0;
      p_q        <= '0;
      scan_cnt_q <= '0;
      digit_q    <= '0;
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
    end else begin
      led_q      <= led_d;
      seg_q      <= seg_d;
      tcnt_q     <= tcnt_d;
      tdiv_q     <= tdiv_d;
      p_q        <= p_d;
      scan_cnt_q <= scan_cnt_d;
      digit_q    <= digit_d;
      sw_s1_q    <= sw;
      sw_s2_q    <= sw_s1_q;
      btn_s1_q   <= btn;
      btn_s2_q   <= btn_s1_q;
    end
  end

  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 8'hC0;
      4'h1: hex7 = 8'hF9;
      4'h2: hex7 = 8'hA4;
      4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99;
      4'h5: hex7 = 8'h92;
      4'h6: hex7 = 8'h82;
      4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80;
      4'h9: hex7 = 8'h90;
      4'hA: hex7 = 8'h88;
      4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6;
      4'hD: hex7 = 8'hA1;
      4'hE: hex7 = 8'h86;
      default: hex7 = 8'h8E;
    endcase
  endfunction

  assign cur_nibble = seg_q[{digit_q, 2'b00} +: 4];
  assign led        = led_q;
  assign seg_en     = ~(8'h01 << digit_q);
  assign seg_code   = hex7(cur_nibble);

endmodule

// File: tb/tb_mem_io_bridge.sv
// tb/tb_mem_io_bridge.sv - randomized self-checking bench for mem_io_bridge
// Expected values come from arithmetic models of the bus, timer and scanner rules.
module tb_mem_io_bridge;
  localparam int AW = 14;
  localparam int SD = 4;
  localparam logic [31:0] PG = 32'hFFFFF000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr;
  logic [3:0]  mem_ctrl;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;
  logic [AW-1:0] dram_addr;
  logic [31:0] dram_wd;
  logic        dram_we;
  logic [31:0] dram_rd;
  logic [23:0] sw;
  logic [4:0]  btn;
  logic [23:0] led;
  logic [7:0]  seg_en;
  logic [7:0]  seg_code;

  logic [31:0] ram [0:(1<<AW)-1];
  logic [31:0] model_mem [int];
  logic [7:0]  hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  int n_checks = 0;
  int n_fail = 0;

  mem_io_bridge #(.DRAM_AW(AW), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_ctrl(mem_ctrl), .mem_wd(mem_wd),
    .mem_we(mem_we), .mem_rd(mem_rd), .dram_addr(dram_addr), .dram_wd(dram_wd),
    .dram_we(dram_we), .dram_rd(dram_rd), .sw(sw), .btn(btn), .led(led),
    .seg_en(seg_en), .seg_code(seg_code)
  );

  always #5 clk = ~clk;

  assign dram_rd = ram[dram_addr];
  always @(posedge clk) if (dram_we) ram[dram_addr] <= dram_wd;

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                           input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    int sh;
    if (sz == 2'b10) begin
      sh = 8 * int'(a[1:0]);
      v = (w >> sh) & 32'hFF;
      if (!uns && v >= 32'h80) v = v - 32'h100;
    end else if (sz == 2'b01) begin
      sh = 16 * int'(a[1]);
      v = (w >> sh) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v - 32'h10000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] a,
                                            input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] mask;
    int sh;
    if (sz == 2'b10) begin
      sh = 8 * int'(a[1:0]);
      mask = 32'hFF << sh;
      return (w & ~mask) | ((d & 32'hFF) << sh);
    end else if (sz == 2'b01) begin
      sh = 16 * int'(a[1]);
      mask = 32'hFFFF << sh;
      return (w & ~mask) | ((d & 32'hFFFF) << sh);
    end
    return d;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [3:0] c, input logic [31:0] d,
                       input logic w);
    mem_addr = a;
    mem_ctrl = c;
    mem_wd   = d;
    mem_we   = w;
    #1;
  endtask

  task automatic idle();
    mem_we   = 1'b0;
    mem_ctrl = 4'h0;
  endtask

  task automatic write_commit(input logic [31:0] a, input logic [31:0] d);
    drive(a, 4'b0001, d, 1'b1);
    cyc();
    idle();
  endtask

  task automatic test_reset();
    logic [31:0] got [4];
    logic [31:0] regs [4] = '{PG | 32'h000, PG | 32'h020, PG | 32'h024, PG | 32'h060};
    rst = 1'b1;
    idle();
    sw = '0;
    btn = '0;
    mem_addr = '0;
    mem_wd = '0;
    cyc();
    cyc();
    rst = 1'b0;
    n_checks++;
    if (led !== 24'h0) begin n_fail++; $display("FAIL reset_led: got %h want 000000", led); end
    n_checks++;
    if (seg_en !== 8'hFE) begin n_fail++; $display("FAIL reset_seg_en: got %h want fe", seg_en); end
    n_checks++;
    if (seg_code !== 8'hC0) begin n_fail++; $display("FAIL reset_seg_code: got %h want c0", seg_code); end
    for (int i = 0; i < 4; i++) begin
      drive(regs[i], 4'b0000, 32'h0, 1'b0);
      got[i] = mem_rd;
      n_checks++;
      if (got[i] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_reg_%h: got %h want 00000000", regs[i][11:0], got[i]);
      end
    end
  endtask

  task automatic test_dram_directed();
    logic [31:0] addrs [5] = '{32'h101, 32'h101, 32'h102, 32'h103, 32'h100};
    logic [3:0]  ctrls [5] = '{4'b0100, 4'b1100, 4'b0010, 4'b1010, 4'b0000};
    logic [31:0] exps  [5] = '{32'hFFFFFFA2, 32'h000000A2, 32'hFFFF8091, 32'h00008091, 32'h8091A2F3};
    write_commit(32'h100, 32'h8091A2F3);
    model_mem[32'h40] = 32'h8091A2F3;
    for (int i = 0; i < 5; i++) begin
      drive(addrs[i], ctrls[i], 32'h0, 1'b0);
      n_checks++;
      if (mem_rd !== exps[i]) begin
        n_fail++;
        $display("FAIL dram_load_%0d: got %h want %h", i, mem_rd, exps[i]);
      end
    end
    write_commit(32'h200, 32'h11223344);
    drive(32'h202, 4'b0101, 32'h000000AB, 1'b1);
    n_checks++;
    if (dram_wd !== 32'h11AB3344) begin n_fail++; $display("FAIL sb_merge: got %h want 11ab3344", dram_wd); end
    n_checks++;
    if (dram_we !== 1'b1) begin n_fail++; $display("FAIL sb_we: got %b want 1", dram_we); end
    drive(32'h200, 4'b0011, 32'h0000BEEF, 1'b1);
    n_checks++;
    if (dram_wd !== 32'h1122BEEF) begin n_fail++; $display("FAIL sh_merge: got %h want 1122beef", dram_wd); end
    cyc();
    idle();
    model_mem[32'h80] = 32'h1122BEEF;
    drive(32'h200, 4'b0000, 32'h0, 1'b0);
    n_checks++;
    if (mem_rd !== 32'h1122BEEF) begin n_fail++; $display("FAIL sh_readback: got %h want 1122beef", mem_rd); end
    drive(PG | 32'h060, 4'b0001, 32'h0, 1'b1);
    n_checks++;
    if (dram_we !== 1'b0) begin n_fail++; $display("FAIL periph_store_dram_we: got %b want 0", dram_we); end
    idle();
  endtask

  task automatic test_dram_random();
    int wa;
    logic [31:0] w, a, d, exp;
    logic [1:0] sz;
    logic uns;
    for (int it = 0; it < 40; it++) begin
      wa = int'($urandom_range(0, (1 << AW) - 1));
      w = $urandom;
      drive(32'(wa) * 4, 4'b0001, w, 1'b1);
      n_checks++;
      if (dram_we !== 1'b1 || dram_wd !== w || dram_addr !== AW'(wa)) begin
        n_fail++;
        $display("FAIL rand_sw_%0d: got we=%b wd=%h addr=%h want we=1 wd=%h addr=%h",
                 it, dram_we, dram_wd, dram_addr, w, AW'(wa));
      end
      cyc();
      idle();
      model_mem[wa] = w;
      a = 32'(wa) * 4 + 32'($urandom_range(0, 3));
      sz = 2'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      drive(a, {uns, sz, 1'b0}, 32'h0, 1'b0);
      exp = ref_load(model_mem[wa], a, sz, uns);
      n_checks++;
      if (mem_rd !== exp) begin
        n_fail++;
        $display("FAIL rand_load_%0d: addr=%h sz=%0d uns=%b got %h want %h", it, a, sz, uns, mem_rd, exp);
      end
      d = $urandom;
      sz = 2'($urandom_range(0, 3));
      exp = ref_store(model_mem[wa], a, sz, d);
      drive(a, {1'b0, sz, 1'b1}, d, 1'b1);
      n_checks++;
      if (dram_wd !== exp || dram_we !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_store_%0d: addr=%h sz=%0d got %h/%b want %h/1", it, a, sz, dram_wd, dram_we, exp);
      end
      cyc();
      idle();
      model_mem[wa] = exp;
      drive(32'(wa) * 4, 4'b0000, 32'h0, 1'b0);
      n_checks++;
      if (mem_rd !== exp) begin
        n_fail++;
        $display("FAIL rand_readback_%0d: got %h want %h", it, mem_rd, exp);
      end
    end
  endtask

  task automatic test_periph();
    logic [23:0] prev_led = 24'h0;
    logic [31:0] v;
    logic [23:0] sw_old = 24'h0, sw_new;
    logic [4:0]  btn_old = 5'h0, btn_new;
    logic [11:0] bad_offs [3] = '{12'h0FC, 12'h004, 12'h800};
    for (int i = 0; i < 3; i++) begin
      v = (i == 0) ? 32'h00ABCDEF : $urandom;
      drive(PG | 32'h060, 4'b0001, v, 1'b1);
      n_checks++;
      if (mem_rd !== {8'h0, prev_led}) begin
        n_fail++;
        $display("FAIL led_same_cycle_%0d: got %h want %h", i, mem_rd, {8'h0, prev_led});
      end
      cyc();
      idle();
      prev_led = v[23:0];
      n_checks++;
      if (led !== prev_led) begin n_fail++; $display("FAIL led_out_%0d: got %h want %h", i, led, prev_led); end
      drive(PG | 32'h060, 4'b0000, 32'h0, 1'b0);
      n_checks++;
      if (mem_rd !== {8'h0, prev_led}) begin
        n_fail++;
        $display("FAIL led_readback_%0d: got %h want %h", i, mem_rd, {8'h0, prev_led});
      end
    end
    v = $urandom;
    write_commit(PG | 32'h000, v);
    drive(PG | 32'h000, 4'b0000, 32'h0, 1'b0);
    n_checks++;
    if (mem_rd !== v) begin n_fail++; $display("FAIL seg_readback: got %h want %h", mem_rd, v); end
    for (int i = 0; i < 3; i++) begin
      write_commit(PG | 32'(bad_offs[i]), $urandom);
      drive(PG | 32'(bad_offs[i]), 4'b0000, 32'h0, 1'b0);
      n_checks++;
      if (mem_rd !== 32'h0 || led !== prev_led) begin
        n_fail++;
        $display("FAIL unmapped_%h: got rd=%h led=%h want rd=00000000 led=%h", bad_offs[i], mem_rd, led, prev_led);
      end
    end
    for (int i = 0; i < 3; i++) begin
      sw_new = (i == 0) ? 24'h123456 : 24'($urandom);
      btn_new = 5'($urandom);
      sw = sw_new;
      btn = btn_new;
      for (int k = 0; k < 3; k++) begin
        drive(PG | 32'h070, 4'b0000, 32'h0, 1'b0);
        n_checks++;
        if (mem_rd !== {8'h0, (k >= 2) ? sw_new : sw_old}) begin
          n_fail++;
          $display("FAIL sw_sync_%0d_%0d: got %h want %h", i, k, mem_rd, {8'h0, (k >= 2) ? sw_new : sw_old});
        end
        drive(PG | 32'h078, 4'b0000, 32'h0, 1'b0);
        n_checks++;
        if (mem_rd !== {27'h0, (k >= 2) ? btn_new : btn_old}) begin
          n_fail++;
          $display("FAIL btn_sync_%0d_%0d: got %h want %h", i, k, mem_rd, {27'h0, (k >= 2) ? btn_new : btn_old});
        end
        cyc();
      end
      sw_old = sw_new;
      btn_old = btn_new;
    end
  endtask

  task automatic read_tcnt_check(input string nm, input logic [31:0] exp);
    drive(PG | 32'h020, 4'b0000, 32'h0, 1'b0);
    n_checks++;
    if (mem_rd !== exp) begin n_fail++; $display("FAIL %s: got %h want %h", nm, mem_rd, exp); end
  endtask

  task automatic test_timer();
    logic [31:0] v, base;
    int n;
    write_commit(PG | 32'h020, 32'h0);
    write_commit(PG | 32'h024, 32'd3);
    for (int k = 0; k <= 10; k++) begin
      read_tcnt_check($sformatf("tdiv3_edge%0d", k), 32'(k / 3));
      cyc();
    end
    write_commit(PG | 32'h020, 32'hFFFFFFFF);
    for (int k = 0; k <= 3; k++) begin
      read_tcnt_check($sformatf("wrap_edge%0d", k), (k < 3) ? 32'hFFFFFFFF : 32'h0);
      cyc();
    end
    write_commit(PG | 32'h020, 32'h10);
    cyc();
    cyc();
    read_tcnt_check("pre_coincide", 32'h10);
    v = $urandom;
    write_commit(PG | 32'h020, v);
    read_tcnt_check("coincide_write", v);
    cyc();
    cyc();
    read_tcnt_check("coincide_plus2", v);
    cyc();
    read_tcnt_check("coincide_plus3", v + 32'd1);
    for (int i = 0; i < 3; i++) begin
      n = int'($urandom_range(1, 6));
      base = $urandom;
      write_commit(PG | 32'h024, 32'(n));
      write_commit(PG | 32'h020, base);
      for (int k = 0; k <= 3 * n + 1; k++) begin
        read_tcnt_check($sformatf("div%0d_edge%0d", n, k), base + 32'(k / n));
        cyc();
      end
    end
    write_commit(PG | 32'h024, 32'h0);
    v = $urandom;
    write_commit(PG | 32'h020, v);
    for (int k = 0; k < 12; k++) cyc();
    read_tcnt_check("frozen", v);
  endtask

  task automatic test_scan();
    logic [31:0] sv;
    int idx;
    logic [7:0] exp_en, exp_code;
    for (int pass = 0; pass < 2; pass++) begin
      sv = (pass == 0) ? 32'h76543210 : $urandom;
      rst = 1'b1;
      idle();
      cyc();
      rst = 1'b0;
      write_commit(PG | 32'h000, sv);
      for (int k = 1; k < 8 * SD * 2 + 2; k++) begin
        idx = (k / SD) % 8;
        exp_en = ~(8'h01 << idx);
        exp_code = hex_tab[(sv >> (4 * idx)) & 32'hF];
        n_checks++;
        if (seg_en !== exp_en || seg_code !== exp_code) begin
          n_fail++;
          $display("FAIL scan_%0d_k%0d: got en=%h code=%h want en=%h code=%h",
                   pass, k, seg_en, seg_code, exp_en, exp_code);
        end
        cyc();
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] regs [4] = '{PG | 32'h000, PG | 32'h020, PG | 32'h024, PG | 32'h060};
    write_commit(PG | 32'h060, $urandom | 32'h1);
    write_commit(PG | 32'h000, $urandom | 32'h10);
    write_commit(PG | 32'h024, 32'd2);
    write_commit(PG | 32'h020, 32'd5);
    write_commit(32'h300, 32'hCAFEF00D);
    for (int k = 0; k < 7; k++) cyc();
    rst = 1'b1;
    drive(32'h300, 4'b0001, 32'h35010FF2, 1'b1);
    n_checks++;
    if (dram_we !== 1'b0) begin n_fail++; $display("FAIL rst_dram_we: got %b want 0", dram_we); end
    cyc();
    n_checks++;
    if (led !== 24'h0 || seg_en !== 8'hFE || seg_code !== 8'hC0) begin
      n_fail++;
      $display("FAIL rst_outputs: got led=%h en=%h code=%h want 000000 fe c0", led, seg_en, seg_code);
    end
    drive(PG | 32'h060, 4'b0001, 32'h00FFFFFF, 1'b1);
    cyc();
    rst = 1'b0;
    idle();
    n_checks++;
    if (led !== 24'h0) begin n_fail++; $display("FAIL rst_led_blocked: got %h want 000000", led); end
    for (int i = 0; i < 4; i++) begin
      drive(regs[i], 4'b0000, 32'h0, 1'b0);
      n_checks++;
      if (mem_rd !== 32'h0) begin
        n_fail++;
        $display("FAIL rst_mid_reg_%h: got %h want 00000000", regs[i][11:0], mem_rd);
      end
    end
    drive(32'h300, 4'b0000, 32'h0, 1'b0);
    n_checks++;
    if (mem_rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rst_dram_kept: got %h want cafef00d", mem_rd); end
    for (int k = 0; k < 5; k++) cyc();
    read_tcnt_check("rst_timer_stopped", 32'h0);
  endtask

  initial begin
    test_reset();
    test_dram_directed();
    test_dram_random();
    test_periph();
    test_timer();
    test_scan();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_io_bridge.md
# mem_io_bridge

Memory/IO bus bridge directly downstream of the single-cycle core's bus port. It consumes the core's address, control, write-data and write-enable outputs and returns read data in the same cycle. Accesses in the DRAM window go to a word-organised data RAM with byte and halfword merge/extract. Accesses in the top 4 KiB page go to the board peripherals: LEDs, switches, buttons, a prescaled timer and an 8-digit seven-segment scanner.

## Interface
- `DRAM_AW`, 14: DRAM word-address width.
- `SCAN_DIV`, 20000: clk cycles per seven-segment digit.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mem_addr` in `IO_BUS_WIDTH_ADDR` (32): byte address.
- `mem_ctrl` in `IO_BUS_WIDTH_CTRL` (4): {unsigned, size[1:0], we}; size 00 word, 01 half, 10 byte, 11 treated as word.
- `mem_wd` in `IO_BUS_WIDTH_DATA` (32): store data, right-aligned.
- `mem_we` in 1: store strobe; authoritative over `mem_ctrl[0]`.
- `mem_rd` out `IO_BUS_WIDTH_DATA` (32): load data, extended.
- `dram_addr` out `DRAM_AW`: `mem_addr[DRAM_AW+1:2]`.
- `dram_wd` out 32: merged word to store.
- `dram_we` out 1: DRAM write, sampled by RAM on clk.
- `dram_rd` in 32: asynchronous RAM read word.
- `sw` in 24: raw switches, asynchronous.
- `btn` in 5: raw buttons, asynchronous.
- `led` out 24: LED register.
- `seg_en` out 8: digit enables, active low.
- `seg_code` out 8: {dp,g,f,e,d,c,b,a}, active low.

## Operation
- Decode: `mem_addr[31:12]==20'hFFFFF` selects the peripheral page; all other addresses select DRAM.
- DRAM load: byte lane `mem_addr[1:0]`.
  - Halfword uses `mem_addr[1]` (bit 0 ignored, aligned down).
  - Word ignores `[1:0]`.
  - Result is zero-extended if unsigned, otherwise sign-extended.
- DRAM store: `dram_wd` is `dram_rd` with the selected byte/half lanes replaced by `mem_wd` low bits. Word store passes `mem_wd`. `dram_we = mem_we & dram_sel`.
- Peripheral registers are word-only: size and unsigned are ignored, full 32 bits are read/written, and `dram_we` stays 0.
  - F000 SEG (RW): 8 hex nibbles, digit i = bits [4i+3:4i].
  - F020 TCNT (RW): timer count.
  - F024 TDIV (RW): prescale divisor; 0 = timer stopped.
  - F060 LED (RW): low 24 bits drive `led`; upper bits read 0.
  - F070 SW (R): synchronised switches, zero-extended.
  - F078 BTN (R): synchronised buttons, zero-extended.
  - Other page offsets read 0; writes to them are ignored.
- Synchroniser: `sw` and `btn` pass through two flops each.
- Timer: 32-bit prescaler `p`.
  - If TDIV≠0: when `p==TDIV-1`, `p` clears and TCNT increments (wraps FFFFFFFF→0). Otherwise `p` increments.
  - Write to TCNT loads it and clears `p`; this wins over a same-cycle tick.
  - Write to TDIV clears `p`.
  - Writing TDIV smaller than current `p` must not stall: the compare is `p>=TDIV-1`.
- Scanner:
  - A counter counts 0..SCAN_DIV-1. On wrap, the digit index (0..7, wraps 7→0) advances.
  - `seg_en` = ~(1<<index).
  - `seg_code` = hex decode of SEG nibble[index], dp always off (bit7=1).
  - Codes 0-F: C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E.

## Timing
- `mem_rd`, `dram_addr`, `dram_wd`, `dram_we` are purely combinational from inputs and register state: zero-cycle loads, as the single-cycle core requires.
- Register writes commit on the rising clk edge of the cycle with `mem_we=1`. A read of the same register in that cycle returns the old value.
- `sw`/`btn` changes are visible in `mem_rd` 2 edges later.
- Timer: with TDIV=N, TCNT increments once every N cycles. The first increment comes N edges after the TDIV write.
- Scanner: each digit stays active for exactly SCAN_DIV cycles.
- Reset (any cycle, including mid-timer or mid-scan):
  - LED=0, SEG=0, TCNT=0, TDIV=0, `p`=0, scan counter=0, index=0.
  - Synchroniser flops are cleared to 0.
  - After reset, `led`=0, `seg_en`=8'hFE, `seg_code`=8'hC0.
  - The DRAM contents are not reset.
- While `rst=1`, the `mem_we` store is blocked: `dram_we`=0 and no peripheral writes occur.

## Test plan
- DRAM byte/half load: RAM word 0x8091A2F3 at addr 0x100.
  - lb 0x101 → 0xFFFFFFA2; lbu 0x101 → 0x000000A2.
  - lh 0x102 → 0xFFFF8091; lhu 0x103 → 0x00008091 (aligned down).
  - lw 0x100 → 0x8091A2F3.
- DRAM partial store: RAM word 0x11223344.
  - sb 0xAB at offset 2 → `dram_wd`=0x11AB3344, `dram_we`=1.
  - sh 0xBEEF at offset 0 → 0x1122BEEF.
  - Peripheral store → `dram_we`=0.
- Peripherals:
  - sw 0x00ABCDEF at F060 → `led`=0xABCDEF the next cycle; readback 0x00ABCDEF.
  - `sw` input set to 0x123456 → F070 reads 0x00123456 from the 2nd edge on.
  - Read of F0FC → 0.
- Timer:
  - TDIV=3 → TCNT reaches 1,2,3 at edges 3,6,9 after the write.
  - TCNT=0xFFFFFFFF then tick → 0.
  - TCNT write coincident with tick → written value.
  - TDIV=0 → TCNT frozen.
- Scanner with SCAN_DIV=4, SEG=0x76543210:
  - `seg_en` steps FE,FD,FB,...,7F,FE every 4 cycles.
  - `seg_code` steps C0,F9,A4,B0,99,92,82,F8.
- Reset mid-operation: assert `rst` with the timer and scan running and LED≠0 → all outputs at reset values on the next edge. Stores in that cycle have no effect.
